// File: rtl/k005297_dmaseq.sv
// K005297 DMA bus-cycle sequencer: ROT8 slot timing, 68000 bus
// arbitration and address-counter control for one page transfer.
module k005297_dmaseq #(
  parameter int MSK_WORDS = 64
) (
  input  logic       i_MCLK,
  input  logic       i_RST,
  input  logic       i_CLK4M_PCEN_n,
  input  logic       i_START,
  input  logic       i_ALD_nB_U,
  input  logic       i_MSK_EN,
  input  logic       i_ABORT,
  input  logic       i_BG_n,
  input  logic       i_AS_n,
  output logic [7:0] o_ROT8,
  output logic       o_ADDR_RST,
  output logic       o_BDRWADDR_INC,
  output logic       o_MSKADDR_INC,
  output logic       o_BR_n,
  output logic       o_BGACK_n,
  output logic       o_DMA_CYC,
  output logic       o_BUSY,
  output logic       o_DONE
);

  typedef enum logic [2:0] {
    IDLE, REQ, OWN, DATA, MASK, REL
  } state_t;

  localparam logic [10:0] MskLim = 11'(MSK_WORDS);

  state_t      state_q, state_d;
  logic [7:0]  rot8_q;
  logic [10:0] cnt_q, cnt_d;
  logic        ald_q, ald_d;
  logic        msk_q, msk_d;
  logic        abort_q, abort_d;
  logic        arst_q, arst_d;
  logic        tick;
  logic [10:0] lim;

  assign tick = ~i_CLK4M_PCEN_n;
  // a 2048-word page wraps the 11-bit counter back to zero
  assign lim  = ald_q ? 11'd256 : 11'd0;

  always_ff @(posedge i_MCLK) begin
    if (tick) begin
      if (i_RST) begin
        state_q <= IDLE;
        rot8_q  <= 8'h01;
        cnt_q   <= '0;
        ald_q   <= 1'b0;
        msk_q   <= 1'b0;
        abort_q <= 1'b0;
        arst_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        rot8_q  <= {rot8_q[6:0], rot8_q[7]};
        cnt_q   <= cnt_d;
        ald_q   <= ald_d;
        msk_q   <= msk_d;
        abort_q <= abort_d;
        arst_q  <= arst_d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ald_d   = ald_q;
    msk_d   = msk_q;
    abort_d = abort_q;
    arst_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_START) begin
          state_d = REQ;
          arst_d  = 1'b1;
          cnt_d   = '0;
          ald_d   = i_ALD_nB_U;
          msk_d   = i_MSK_EN;
          abort_d = 1'b0;
        end
      end
      REQ: begin
        if (i_ABORT) begin
          state_d = REL;
          abort_d = 1'b1;
        end else if (!i_BG_n && i_AS_n) begin
          state_d = OWN;
        end
      end
      OWN: begin
        if (i_ABORT) begin
          state_d = REL;
          abort_d = 1'b1;
        end else if (rot8_q[7]) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (i_ABORT) begin
          state_d = REL;
          abort_d = 1'b1;
        end else begin
          if (rot8_q[1]) cnt_d = cnt_q + 11'd1;
          if (rot8_q[7] && cnt_q == lim) begin
            cnt_d   = '0;
            state_d = msk_q ? MASK : REL;
          end
        end
      end
      MASK: begin
        if (i_ABORT) begin
          state_d = REL;
          abort_d = 1'b1;
        end else begin
          if (rot8_q[1]) cnt_d = cnt_q + 11'd1;
          if (rot8_q[7] && cnt_q == MskLim) begin
            cnt_d   = '0;
            state_d = REL;
          end
        end
      end
      REL:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_ROT8         = rot8_q;
  assign o_ADDR_RST     = arst_q;
  assign o_BDRWADDR_INC = (state_q == DATA);
  assign o_MSKADDR_INC  = (state_q == MASK);
  assign o_BR_n         = (state_q != REQ);
  assign o_BGACK_n      = !(state_q == OWN || state_q == DATA ||
                            state_q == MASK);
  assign o_DMA_CYC      = (state_q == DATA || state_q == MASK) &&
                          (|rot8_q[6:2]);
  assign o_BUSY         = (state_q != IDLE);
  assign o_DONE         = (state_q == REL) && !abort_q;

endmodule

// File: tb/tb_k005297_dmaseq.sv
// Scoreboard bench for k005297_dmaseq: per-transfer summaries are
// queued by stimulus and checked by a monitor when BUSY drops.
module tb_k005297_dmaseq;

  logic       clk = 1'b0;
  logic       rst, pcen_n, start, ald, msk_en, abort_i, bg_n, as_n;
  logic [7:0] rot8;
  logic       addr_rst, bdrw, msk, br_n, bgack_n, dma, busy, done;
  logic       en_mode = 1'b0;
  logic       ph = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int arst; int data; int mask; int strobes; int cyc;
    int done; int overlap; int misalign; int badlen;
  } rec_t;

  rec_t exp_q[$];

  k005297_dmaseq #(.MSK_WORDS(64)) dut (
    .i_MCLK(clk), .i_RST(rst), .i_CLK4M_PCEN_n(pcen_n),
    .i_START(start), .i_ALD_nB_U(ald), .i_MSK_EN(msk_en),
    .i_ABORT(abort_i), .i_BG_n(bg_n), .i_AS_n(as_n),
    .o_ROT8(rot8), .o_ADDR_RST(addr_rst),
    .o_BDRWADDR_INC(bdrw), .o_MSKADDR_INC(msk),
    .o_BR_n(br_n), .o_BGACK_n(bgack_n), .o_DMA_CYC(dma),
    .o_BUSY(busy), .o_DONE(done)
  );

  always #5 clk = ~clk;

  initial pcen_n = 1'b0;
  always @(negedge clk) begin
    ph     <= ~ph;
    pcen_n <= en_mode ? ph : 1'b0;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    do @(posedge clk); while (pcen_n);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return bdrw;
      1:       return msk;
      2:       return exp_q.size() == 0;
      default: return exp_q.size() <= 1;
    endcase
  endfunction

  task automatic wait_for(input string nm, input int sel,
                          input int lim);
    int n = 0;
    while (!cond(sel) && n < lim) begin
      tick();
      n++;
    end
    if (!cond(sel)) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout after %0d ticks", nm, lim);
      if (sel >= 2) exp_q.delete();
    end
  endtask

  function automatic rec_t mk(input int d, input int m, input int s,
                              input int c, input int dn);
    rec_t r;
    r = '{arst: 1, data: d, mask: m, strobes: s, cyc: c, done: dn,
          overlap: 0, misalign: 0, badlen: 0};
    return r;
  endfunction

  // monitor: accumulate each transfer, compare when BUSY falls
  initial begin
    rec_t cur, e;
    bit pb, pd, pbd;
    int slen;
    cur = '{default: 0};
    pb = 0; pd = 0; pbd = 0; slen = 0;
    forever begin
      @(posedge clk);
      if (!pcen_n) begin
        #1;
        if (busy) begin
          cur.arst += int'(addr_rst);
          cur.data += int'(bdrw);
          cur.mask += int'(msk);
          cur.cyc  += int'(dma);
          cur.done += int'(done);
          if (bdrw && msk) cur.overlap++;
          if (bdrw && !pbd && rot8 != 8'h01) cur.misalign++;
          if (dma && !pd) cur.strobes++;
          if (dma) slen++;
          if (!dma && pd) begin
            if ((bdrw || msk) && slen != 5) cur.badlen++;
            slen = 0;
          end
          pd = dma;
          pbd = bdrw;
        end else if (pb) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected: got transfer end expected none");
          end else begin
            e = exp_q.pop_front();
            chk("sb_addr_rst", cur.arst, e.arst);
            chk("sb_data_ticks", cur.data, e.data);
            chk("sb_mask_ticks", cur.mask, e.mask);
            chk("sb_strobes", cur.strobes, e.strobes);
            chk("sb_cyc_ticks", cur.cyc, e.cyc);
            chk("sb_done", cur.done, e.done);
            chk("sb_overlap", cur.overlap, e.overlap);
            chk("sb_misalign", cur.misalign, e.misalign);
            chk("sb_strobe_len", cur.badlen, e.badlen);
          end
          cur = '{default: 0};
          pd = 0; pbd = 0; slen = 0;
        end
        pb = busy;
      end
    end
  end

  initial begin
    logic [7:0] r_save;
    int bad;
    rst = 1; start = 0; ald = 1; msk_en = 0; abort_i = 0;
    bg_n = 0; as_n = 1;
    ticks(2);
    chk("rst_rot8", int'(rot8), 8'h01);
    chk("rst_br_n", int'(br_n), 1);
    chk("rst_bgack_n", int'(bgack_n), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_flags", int'({addr_rst, bdrw, msk, dma, done}), 0);
    rst = 0;
    tick();
    chk("rot8_rotates", int'(rot8), 8'h02);

    // 1: user page, no mask
    exp_q.push_back(mk(2048, 0, 256, 1280, 1));
    start = 1;
    tick();
    start = 0;
    chk("t1_addr_rst", int'(addr_rst), 1);
    chk("t1_br_n", int'(br_n), 0);
    wait_for("t1_drain", 2, 3000);
    chk("t1_bgack_n", int'(bgack_n), 1);

    // 2: bootloader page with error map
    ald = 0; msk_en = 1;
    exp_q.push_back(mk(16384, 512, 2112, 10560, 1));
    start = 1;
    tick();
    start = 0; ald = 1; msk_en = 0;
    wait_for("t2_drain", 2, 20000);

    // 3: bus contention
    bg_n = 1; as_n = 0;
    exp_q.push_back(mk(2048, 0, 256, 1280, 1));
    start = 1;
    tick();
    start = 0; bg_n = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!bgack_n || br_n) bad++;
    end
    chk("t3_hold_off", bad, 0);
    as_n = 1;
    tick();
    chk("t3_bgack_n", int'(bgack_n), 0);
    chk("t3_br_n", int'(br_n), 1);
    wait_for("t3_drain", 2, 3000);

    // 4: abort in data slot 100 at ROT8[4]
    exp_q.push_back(mk(797, 0, 100, 498, 0));
    start = 1;
    tick();
    start = 0;
    wait_for("t4_data", 0, 50);
    ticks(796);
    chk("t4_rot8", int'(rot8), 8'h10);
    abort_i = 1;
    tick();
    abort_i = 0;
    chk("t4_abort_outs", int'({bdrw, dma, done}), 0);
    chk("t4_bgack_n", int'(bgack_n), 1);
    chk("t4_busy_rel", int'(busy), 1);
    tick();
    chk("t4_idle", int'(busy), 0);
    wait_for("t4_drain", 2, 10);

    // 5: reset during mask with gated enables
    en_mode = 1;
    msk_en = 1;
    exp_q.push_back(mk(2048, 20, 259, 1292, 0));
    start = 1;
    tick();
    start = 0; msk_en = 0;
    wait_for("t5_mask", 1, 3000);
    ticks(19);
    rst = 1;
    r_save = rot8;
    @(posedge clk);
    #2;
    chk("t5_gated_rot8", int'(rot8), int'(r_save));
    chk("t5_gated_msk", int'(msk), 1);
    tick();
    rst = 0;
    chk("t5_rot8", int'(rot8), 8'h01);
    chk("t5_bus", int'({br_n, bgack_n}), 3);
    chk("t5_flags", int'({addr_rst, bdrw, msk, dma, done, busy}), 0);
    wait_for("t5_drain", 2, 10);
    en_mode = 0;

    // 6: start held high, input changes mid-transfer
    exp_q.push_back(mk(2048, 0, 256, 1280, 1));
    exp_q.push_back(mk(2048, 0, 256, 1280, 1));
    start = 1;
    tick();
    wait_for("t6_data", 0, 50);
    ticks(100);
    ald = 0; msk_en = 1;
    wait_for("t6_first", 3, 3000);
    ald = 1; msk_en = 0;
    ticks(10);
    start = 0;
    wait_for("t6_drain", 2, 3000);
    ticks(20);
    chk("t6_no_restart", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/k005297_dmaseq.md
Name: k005297_dmaseq

Overview:
DMA bus-cycle sequencer directly upstream of the DMA address counter. It generates the one-hot ROT8 slot timing, arbitrates the 68000 bus (BR/BG/BGACK), and drives the address-counter controls (ADDR_RST, BDRWADDR_INC, MSKADDR_INC) for one page transfer. A page transfer is a data phase followed by an optional error-map phase. It reports completion to the bubble controller core.

Parameters:
MSK_WORDS, 64, error-map words per page; legal range 1..256.

Ports:
i_MCLK  in  1  master clock
i_RST  in  1  reset, synchronous, active-high
i_CLK4M_PCEN_n  in  1  4 MHz clock enable, active-low; every state change qualifies on it
i_START  in  1  page transfer request, level sampled in IDLE
i_ALD_nB_U  in  1  0 = bootloader page (2048 words), 1 = user page (256 words)
i_MSK_EN  in  1  run error-map phase after data phase
i_ABORT  in  1  terminate the transfer
i_BG_n  in  1  bus grant from CPU
i_AS_n  in  1  CPU address strobe (bus busy when low)
o_ROT8  out  8  one-hot slot timing to the address counter
o_ADDR_RST  out  1  address counter reset strobe
o_BDRWADDR_INC  out  1  data address increment enable
o_MSKADDR_INC  out  1  error-map address increment enable / AOUT select
o_BR_n  out  1  bus request
o_BGACK_n  out  1  bus grant acknowledge
o_DMA_CYC  out  1  DMA bus cycle strobe
o_BUSY  out  1  transfer in progress
o_DONE  out  1  completion pulse

Behaviour:
- Enable: "tick" means a rising edge of i_MCLK with i_CLK4M_PCEN_n = 0. Nothing changes on non-tick edges. i_RST is also checked on ticks only.
- ROT8: rotates left by one bit per tick, wrapping bit 7 to bit 0. It free-runs in every state. Reset value 8'h01. A slot is the eight ticks from ROT8[0] through ROT8[7].
- Reset values: state IDLE, word counter 0, o_ROT8 8'h01, o_BR_n 1, o_BGACK_n 1, all other outputs 0.
- FSM states: IDLE, REQ, OWN, DATA, MASK, REL.
- IDLE to REQ: on a tick with i_START = 1.
  - o_ADDR_RST is high for exactly that one tick period.
  - o_BUSY goes high; word counter cleared.
- REQ: o_BR_n = 0. Moves to OWN on the first tick where i_BG_n = 0 and i_AS_n = 1.
- OWN: o_BGACK_n = 0 and o_BR_n = 1. Moves to DATA on the tick where ROT8[7] = 1, so DATA always begins on a slot boundary.
- DATA:
  - o_BDRWADDR_INC = 1 for the whole state.
  - Counter limit: 2048 if i_ALD_nB_U = 0, else 256. i_ALD_nB_U is sampled at IDLE exit and held.
  - The 11-bit word counter increments at ROT8[1].
  - At ROT8[7] with count = limit: clear the counter, then go to MASK if the latched i_MSK_EN = 1, else go to REL.
- MASK:
  - o_MSKADDR_INC = 1 for the whole state; o_BDRWADDR_INC = 0.
  - Counter increments at ROT8[1]. At ROT8[7] with count = MSK_WORDS, go to REL.
- o_DMA_CYC: 1 during ROT8[2] through ROT8[6] of every DATA or MASK slot, otherwise 0. The last slot of each phase produces a full strobe.
- REL: o_BGACK_n = 1. o_DONE = 1 for one tick period. Return to IDLE on the next tick; o_BUSY drops there.
- Abort: i_ABORT = 1 in REQ, OWN, DATA or MASK goes to REL on the same tick, but without o_DONE.
  - All increment enables and o_DMA_CYC drop immediately.
  - An abort during REQ also releases o_BR_n.
- Start while busy: i_START outside IDLE is ignored. A level still high on return to IDLE starts a new transfer.
- Reset mid-operation: returns to reset values on the next tick, with no DONE pulse. o_BR_n and o_BGACK_n deassert within one tick.
- Simultaneous events: i_ABORT has priority over phase completion. i_RST has priority over everything.

Test Plan:
1. User page with i_ALD_nB_U=1 and i_MSK_EN=0, grant given immediately:
   - one o_ADDR_RST pulse; o_BDRWADDR_INC high for exactly 256 slots (2048 ticks);
   - 256 o_DMA_CYC strobes of 5 ticks each; o_DONE pulses once; o_BGACK_n returns to 1.
2. Bootloader page with MSK_WORDS=64 and i_MSK_EN=1:
   - 2048 data slots, then 64 mask slots; o_MSKADDR_INC never overlaps o_BDRWADDR_INC;
   - o_DONE pulses after slot 2112.
3. Bus contention, i_AS_n held low for 20 ticks after i_BG_n=0:
   - o_BGACK_n stays 1 until i_AS_n rises;
   - the first data slot begins at the ROT8[0] that follows.
4. i_ABORT for one tick at data slot 100, ROT8[4]:
   - next tick: o_BDRWADDR_INC=0, o_DMA_CYC=0, o_BGACK_n=1;
   - no o_DONE pulse; IDLE two ticks later.
5. i_RST asserted during MASK, with toggles between enables:
   - all outputs equal the reset values after the first tick;
   - ROT8 = 8'h01; no state change occurs on non-enabled edges.
6. i_START held high continuously:
   - back-to-back transfers, each beginning with exactly one o_ADDR_RST pulse;
   - i_START changes during a transfer have no effect.
